// File: rtl/beep_generator.sv
// Piezo beep sequencer: plays num_beeps tone bursts separated by silent gaps; outputs are registered (1-cycle latency from trigger).
// No backpressure: trigger while busy is dropped, stop aborts at once without a done pulse.
module beep_generator #(
    parameter int TONE_HALF = 12500,
    parameter int BEEP_ON   = 3000000,
    parameter int BEEP_OFF  = 3000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [3:0] num_beeps,
    input  logic       stop,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    localparam logic [23:0] TONE_LAST = 24'(TONE_HALF - 1);
    localparam logic [23:0] ON_LAST   = 24'(BEEP_ON - 1);
    localparam logic [23:0] OFF_LAST  = 24'(BEEP_OFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] phase_q, phase_d;
    logic [23:0] tone_cnt_q, tone_cnt_d;
    logic        tone_q, tone_d;
    logic [3:0]  rem_q, rem_d;
    logic        buzzer_q, buzzer_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        rem_d      = rem_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trigger && !stop && (num_beeps != 4'd0)) begin
                    state_d    = S_ON;
                    rem_d      = num_beeps;
                    phase_d    = 24'd0;
                    tone_cnt_d = 24'd0;
                    tone_d     = 1'b1;
                end
            end
            S_ON: begin
                if (stop) begin
                    state_d    = S_IDLE;
                    phase_d    = 24'd0;
                    tone_cnt_d = 24'd0;
                    tone_d     = 1'b0;
                    rem_d      = 4'd0;
                end else if (phase_q == ON_LAST) begin
                    phase_d    = 24'd0;
                    tone_cnt_d = 24'd0;
                    tone_d     = 1'b0;
                    if (rem_q > 4'd1) begin
                        state_d = S_OFF;
                        rem_d   = rem_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        rem_d   = 4'd0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 24'd1;
                    if (tone_cnt_q == TONE_LAST) begin
                        tone_cnt_d = 24'd0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 24'd1;
                    end
                end
            end
            S_OFF: begin
                if (stop) begin
                    state_d = S_IDLE;
                    phase_d = 24'd0;
                    rem_d   = 4'd0;
                end else if (phase_q == OFF_LAST) begin
                    // each beep restarts its tone on the high phase
                    state_d    = S_ON;
                    phase_d    = 24'd0;
                    tone_cnt_d = 24'd0;
                    tone_d     = 1'b1;
                end else begin
                    phase_d = phase_q + 24'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                phase_d    = 24'd0;
                tone_cnt_d = 24'd0;
                tone_d     = 1'b0;
                rem_d      = 4'd0;
            end
        endcase

        buzzer_d = (state_d == S_ON) && tone_d;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 24'd0;
            tone_cnt_q <= 24'd0;
            tone_q     <= 1'b0;
            rem_q      <= 4'd0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            rem_q      <= rem_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign buzzer = buzzer_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_beep_generator.sv
// Bench for beep_generator: fixed vector table, directed corner sequences, random traffic vs a schedule model.
module tb_beep_generator;

    localparam int TH  = 2;
    localparam int ON  = 8;
    localparam int OFF = 4;

    logic       clk = 1'b0;
    logic       rst, trigger, stop;
    logic [3:0] num_beeps;
    logic       buzzer, busy, done;

    beep_generator #(.TONE_HALF(TH), .BEEP_ON(ON), .BEEP_OFF(OFF)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .num_beeps(num_beeps),
        .stop(stop), .buzzer(buzzer), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       trig;
        logic [3:0] nb;
        logic [2:0] exp; // {busy, buzzer, done}
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: a sequence is just a start cycle and a beep count; outputs follow by arithmetic.
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_n      = 0;

    function automatic void model_out(input int c, output logic b, output logic bz, output logic d);
        int off, total, w;
        b = 1'b0; bz = 1'b0; d = 1'b0;
        if (m_active && c >= m_start) begin
            off   = c - m_start;
            total = m_n * ON + (m_n - 1) * OFF;
            if (off < total) begin
                b = 1'b1;
                w = off % (ON + OFF);
                if (w < ON) bz = ((w / TH) % 2) == 0;
            end else if (off == total) begin
                d = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d {busy,buzzer,done} got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [3:0] nb, input logic s);
        logic eb, ez, ed;
        rst = r; trigger = t; num_beeps = nb; stop = s;
        model_out(cyc, eb, ez, ed);
        chk("model", {busy, buzzer, done}, {eb, ez, ed});
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
        end else if (eb) begin
            if (s) m_active = 1'b0;
        end else if (t && !s && nb != 4'd0) begin
            m_active = 1'b1;
            m_start  = cyc + 1;
            m_n      = int'(nb);
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wait_done(input int t0, input int exp_off, input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            k++;
        end
        checks++;
        if (done !== 1'b1 || (cyc - t0) != exp_off) begin
            failures++;
            $display("FAIL %s done_offset got=%0d exp=%0d done=%b", name, cyc - t0, exp_off, done);
        end
    endtask

    initial begin
        vec_t        vec [23];
        logic [0:22] bz_p, by_p, dn_p;
        int          t0;
        logic        seen;

        bz_p = 23'b0_11001100_0000_11001100_0_0;
        by_p = 23'b0_11111111_1111_11111111_0_0;
        dn_p = 23'b0_00000000_0000_00000000_1_0;
        for (int i = 0; i < 23; i++) begin
            vec[i].trig = (i == 0);
            vec[i].nb   = 4'd2;
            vec[i].exp  = {by_p[i], bz_p[i], dn_p[i]};
        end

        rst = 1'b1; trigger = 1'b0; stop = 1'b0; num_beeps = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, buzzer, done}, 3'b000);

        // reset wins over trigger
        step(1'b1, 1'b1, 4'd3, 1'b0);
        chk("rst_over_trig", {busy, buzzer, done}, 3'b000);

        // two-beep waveform, cycle by cycle
        for (int i = 0; i < 23; i++) begin
            chk("table", {busy, buzzer, done}, vec[i].exp);
            step(1'b0, vec[i].trig, vec[i].nb, 1'b0);
        end

        // zero beeps: silent for 30 cycles
        step(1'b0, 1'b1, 4'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen = seen | busy | buzzer | done;
            idle(1);
        end
        chk("nb0_quiet", {2'b00, seen}, 3'b000);

        // stop beats trigger in idle
        step(1'b0, 1'b1, 4'd5, 1'b1);
        chk("stop_over_trig", {busy, buzzer, done}, 3'b000);
        idle(2);

        // retrigger while busy is ignored
        t0 = cyc;
        step(1'b0, 1'b1, 4'd3, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        wait_done(t0, 3 * ON + 2 * OFF + 1, "done_3beeps");
        idle(3);

        // trigger on the done cycle is accepted
        t0 = cyc;
        step(1'b0, 1'b1, 4'd1, 1'b0);
        wait_done(t0, ON + 1, "done_1beep");
        step(1'b0, 1'b1, 4'd1, 1'b0);
        chk("retrig_busy", {busy, 1'b0, done}, 3'b100);
        wait_done(t0, 2 * ON + 2, "done_retrig");
        idle(3);

        // stop during the gap
        t0 = cyc;
        step(1'b0, 1'b1, 4'd2, 1'b0);
        while (cyc < t0 + 10) idle(1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("stop_abort", {busy, buzzer, done}, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | done;
            idle(1);
        end
        chk("stop_no_done", {2'b00, seen}, 3'b000);

        // reset mid-beep, then a clean replay
        t0 = cyc;
        step(1'b0, 1'b1, 4'd2, 1'b0);
        while (cyc < t0 + 4) idle(1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("rst_abort", {busy, buzzer, done}, 3'b000);
        idle(1);
        step(1'b0, 1'b1, 4'd2, 1'b0);
        wait_done(t0 + 6, 2 * ON + OFF + 1, "after_rst");
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 15) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
